// File: rtl/gpio_input_debounce_irq.sv
// GPIO input debounce and edge-triggered interrupt pending logic.
// Sits between the two-flop input synchroniser and the APB GPIO register file.
// Optional feature macro: GPIO_DEBOUNCE_EN. When defined, a prescaled sample
// tick and per-pin stability counters filter the inputs. When undefined,
// io_value follows io_dataIn with one cycle of latency, and PRESCALE,
// STABLE_TICKS and CNT_W are ignored.
module gpio_input_debounce_irq #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned PRESCALE     = 1000,
  parameter int unsigned STABLE_TICKS = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic             io_mainClk,
  input  logic             resetCtrl_systemReset,
  input  logic [WIDTH-1:0] io_dataIn,
  input  logic [WIDTH-1:0] io_riseEnable,
  input  logic [WIDTH-1:0] io_fallEnable,
  input  logic [WIDTH-1:0] io_clearPending,
  output logic [WIDTH-1:0] io_value,
  output logic [WIDTH-1:0] io_pending,
  output logic             io_interrupt
);

  logic [WIDTH-1:0] value_next;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] pending_set;
  logic [WIDTH-1:0] pending_next;

  // Reject parameter sets where the counter cannot reach STABLE_TICKS-1
  if (PRESCALE < 1 || STABLE_TICKS < 1 || CNT_W < 1 ||
      (64'd1 << CNT_W) < 64'(STABLE_TICKS)) begin : g_param_check
    $error("gpio_input_debounce_irq: illegal PRESCALE/STABLE_TICKS/CNT_W");
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic [PS_W-1:0]  prescale_q;
  logic             tick;
  logic [CNT_W-1:0] cnt_q    [WIDTH];
  logic [CNT_W-1:0] cnt_next [WIDTH];

  assign tick = (prescale_q == PS_LAST);

  // Free-running sample-tick prescaler, wraps at PRESCALE-1
  always_ff @(posedge io_mainClk) begin
    if (resetCtrl_systemReset) begin
      prescale_q <= '0;
    end else if (tick) begin
      prescale_q <= '0;
    end else begin
      prescale_q <= prescale_q + PS_W'(1);
    end
  end

  // Per-pin stability count; any return to the debounced level restarts it
  always_comb begin
    value_next = io_value;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt_next[i] = cnt_q[i];
      if (io_dataIn[i] == io_value[i]) begin
        cnt_next[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == CNT_LAST) begin
          value_next[i] = io_dataIn[i];
          cnt_next[i]   = '0;
        end else begin
          cnt_next[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Stability counter registers; reset discards partial counts
  always_ff @(posedge io_mainClk) begin
    if (resetCtrl_systemReset) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_next;
    end
  end
`else
  // Debounce bypassed: accept the synchronised level every cycle
  always_comb begin
    value_next = io_dataIn;
  end
`endif

  // Edges are taken against the value about to be registered
  always_comb begin
    rise         = ~io_value & value_next;
    fall         = io_value & ~value_next;
    pending_set  = (rise & io_riseEnable) | (fall & io_fallEnable);
    pending_next = pending_set | (io_pending & ~io_clearPending);
  end

  // Debounced value and pending registers
  always_ff @(posedge io_mainClk) begin
    if (resetCtrl_systemReset) begin
      io_value   <= '0;
      io_pending <= '0;
    end else begin
      io_value   <= value_next;
      io_pending <= pending_next;
    end
  end

  assign io_interrupt = |io_pending;

endmodule

// File: tb/tb_gpio_input_debounce_irq.sv
// Scoreboard bench for gpio_input_debounce_irq with a behavioural model.
`timescale 1ns/1ps
module tb_gpio_input_debounce_irq;

  localparam int unsigned WIDTH        = 32;
  localparam int unsigned PRESCALE     = 4;
  localparam int unsigned STABLE_TICKS = 3;
  localparam int unsigned CNT_W        = 2;

  typedef struct packed {
    logic [WIDTH-1:0] value;
    logic [WIDTH-1:0] pending;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] value;
  logic [WIDTH-1:0] pending;
  logic             irq;

  always #5 clk = ~clk;

  gpio_input_debounce_irq #(
    .WIDTH(WIDTH), .PRESCALE(PRESCALE), .STABLE_TICKS(STABLE_TICKS), .CNT_W(CNT_W)
  ) dut (
    .io_mainClk(clk),
    .resetCtrl_systemReset(rst),
    .io_dataIn(data_in),
    .io_riseEnable(rise_en),
    .io_fallEnable(fall_en),
    .io_clearPending(clr),
    .io_value(value),
    .io_pending(pending),
    .io_interrupt(irq)
  );

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state
  logic [WIDTH-1:0] m_value;
  logic [WIDTH-1:0] m_pending;
  int               m_cycle;
  int               m_run [WIDTH];

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Drive one cycle of inputs and push the state expected after the next edge
  task automatic step(input logic r, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] ren,
                      input logic [WIDTH-1:0] fen, input logic [WIDTH-1:0] cl);
    exp_t             e;
    logic [WIDTH-1:0] nv;
    bit               tk;
    @(negedge clk);
    rst = r; data_in = d; rise_en = ren; fall_en = fen; clr = cl;
    if (r) begin
      m_value   = '0;
      m_pending = '0;
      m_cycle   = 0;
      for (int i = 0; i < int'(WIDTH); i++) m_run[i] = 0;
    end else begin
`ifdef GPIO_DEBOUNCE_EN
      // A sample tick falls on every PRESCALE-th cycle after reset release
      tk = ((m_cycle % int'(PRESCALE)) == int'(PRESCALE) - 1);
      nv = m_value;
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (d[i] != m_value[i]) begin
          if (tk) begin
            m_run[i]++;
            if (m_run[i] == int'(STABLE_TICKS)) begin
              nv[i]    = d[i];
              m_run[i] = 0;
            end
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_cycle++;
`else
      tk = 1'b0;
      nv = d;
`endif
      m_pending = ((~m_value & nv & ren) | (m_value & ~nv & fen)) | (m_pending & ~cl);
      m_value   = nv;
    end
    e.value   = m_value;
    e.pending = m_pending;
    exp_q.push_back(e);
  endtask

  task automatic hold(input int n, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] ren,
                      input logic [WIDTH-1:0] fen, input logic [WIDTH-1:0] cl);
    for (int k = 0; k < n; k++) step(1'b0, d, ren, fen, cl);
  endtask

  // Monitor: compare DUT outputs against the queued expectation each cycle
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("value", value, e.value);
        check("pending", pending, e.pending);
        check("interrupt", WIDTH'(irq), WIDTH'(|e.pending));
      end
    end
  end

  initial begin : stimulus
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] ren;
    logic [WIDTH-1:0] fen;
    logic [WIDTH-1:0] cl;
    rst = 1'b1; data_in = '0; rise_en = '0; fall_en = '0; clr = '0;

    // Reset held with all inputs high
    for (int k = 0; k < 3; k++) step(1'b1, '1, '1, '1, '0);

    // Clean rise on pin 0 with rise enabled
    hold(4, '0, 32'h1, '0, '0);
    hold(16, 32'h1, 32'h1, '0, '0);

    // Short glitch on pin 5
    hold(6, 32'h21, '1, '1, '0);
    hold(12, 32'h1, '1, '1, '0);

    // Fall on pin 2 masked, then enabled
    hold(16, 32'h5, '0, '0, '0);
    hold(16, 32'h1, '0, '0, '0);
    hold(16, 32'h5, '0, '0, '0);
    hold(16, 32'h1, '0, 32'h4, '0);

    // Clear everything, then clears held while a new rise on pin 0 sets
    hold(1, 32'h1, '0, '0, '1);
    hold(16, '0, '0, '0, '0);
    hold(16, 32'h1, 32'h1, '0, 32'h1);
    hold(2, 32'h1, 32'h1, '0, '0);
    hold(1, 32'h1, '0, '0, 32'h1);

    // Pattern with all enables
    hold(16, 32'hA5A5_A5A5, '1, '1, '0);
    hold(16, 32'h5A5A_5A5A, '1, '1, '0);

    // Randomised traffic with a mid-run reset
    d = 32'hA5A5_A5A5; ren = '1; fen = '1;
    for (int k = 0; k < 600; k++) begin
      if (k % 32 == 0) begin
        ren = $urandom;
        fen = $urandom;
      end
      if (k % 64 < 40) d = d ^ ($urandom & $urandom & $urandom);
      cl = ($urandom_range(0, 7) == 0) ? WIDTH'($urandom) : '0;
      if (k >= 300 && k < 302) step(1'b1, d, ren, fen, cl);
      else step(1'b0, d, ren, fen, cl);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", WIDTH'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gpio_input_debounce_irq.md
Name: gpio_input_debounce_irq

Overview:
- Consumes the synchronised 32-bit GPIO input word from the two-flop input synchroniser and produces a debounced pin value plus per-pin edge-triggered interrupt pending bits.
- Sits between the input synchroniser and the APB GPIO register file.
- The register file supplies the enable masks and write-1-to-clear pulses, and reads back the value and pending bits.
- Drives a single OR-reduced interrupt line to the interrupt controller.

Parameters:
- WIDTH, 32, number of GPIO pins.
- PRESCALE, 1000, io_mainClk cycles per debounce sample tick (>=1).
- STABLE_TICKS, 4, consecutive ticks a pin must differ from its debounced value before it is accepted (>=1).
- CNT_W, 3, per-pin stability counter width; must satisfy 2^CNT_W >= STABLE_TICKS.

Ports:
- io_mainClk  input  1  system clock
- resetCtrl_systemReset  input  1  reset, synchronous to io_mainClk, active-high
- io_dataIn  input  WIDTH  synchronised raw pin levels
- io_riseEnable  input  WIDTH  per-pin enable: rising debounced edge sets pending
- io_fallEnable  input  WIDTH  per-pin enable: falling debounced edge sets pending
- io_clearPending  input  WIDTH  one-cycle write-1-to-clear pulses for pending bits
- io_value  output  WIDTH  debounced pin levels (registered)
- io_pending  output  WIDTH  interrupt pending bits (registered)
- io_interrupt  output  1  OR of io_pending (combinational from pending register)

Behaviour:
- Interface: one clock, io_mainClk; reset resetCtrl_systemReset is synchronous and active-high.
- Reset (sampled on io_mainClk rising edge while high):
  - prescaler = 0, all stability counters = 0.
  - io_value = 0, io_pending = 0, so io_interrupt = 0.
  - Reset mid-debounce discards partial counts.
  - No edge or pending event is generated in the cycle leaving reset.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps to 0.
  - tick is asserted in the cycle where prescaler == PRESCALE-1.
  - With PRESCALE=1, tick is asserted every cycle.
- Per-pin debounce, evaluated every cycle:
  - io_dataIn[i] == io_value[i]: cnt[i] <= 0 immediately, whether or not tick is asserted. Any glitch back restarts the count.
  - Differs, tick=1, cnt[i] < STABLE_TICKS-1: cnt[i] <= cnt[i]+1.
  - Differs, tick=1, cnt[i] == STABLE_TICKS-1: io_value[i] <= io_dataIn[i], cnt[i] <= 0.
  - Differs, tick=0: cnt[i] holds.
  - Net effect: io_value updates on the edge of the STABLE_TICKS-th consecutive tick on which the pin differed.
  - Counters never exceed STABLE_TICKS-1; no wrap.
- Edge detect, computed on the next-state value:
  - rise[i] = ~io_value[i] & value_next[i]
  - fall[i] = io_value[i] & ~value_next[i]
- Pending:
  - set[i] = (rise[i] & io_riseEnable[i]) | (fall[i] & io_fallEnable[i])
  - pending_next = set | (io_pending & ~io_clearPending)
  - Set wins over a clear in the same cycle.
  - Pending asserts on the same clock edge as the io_value change.
  - Enable masks gate only new sets; clearing an enable does not clear existing pending bits.
- io_interrupt = |io_pending.
- Latency: raw change to io_value change is between (STABLE_TICKS-1)*PRESCALE+1 and STABLE_TICKS*PRESCALE cycles, depending on prescaler phase.

Optional Feature:
- Macro: GPIO_DEBOUNCE_EN.
- Defined: prescaler and stability counters are present, with behaviour as above.
- Undefined:
  - No prescaler or counters are instantiated.
  - io_value <= io_dataIn every cycle (1-cycle latency).
  - Parameters PRESCALE, STABLE_TICKS and CNT_W are ignored.
  - Edge and pending logic are unchanged.

Test Plan:
- Reset: assert reset with io_dataIn=32'hFFFF_FFFF for 3 cycles -> io_value=0, io_pending=0, io_interrupt=0 while held; first value change occurs no earlier than STABLE_TICKS ticks after release.
- Clean rise (PRESCALE=4, STABLE_TICKS=3, io_riseEnable=32'h1): set io_dataIn[0]=1 and hold -> io_value[0]=1 within 9..12 cycles; io_pending=32'h1 and io_interrupt=1 on the same edge.
- Glitch rejection: pulse io_dataIn[5] high for 6 cycles, then low (PRESCALE=4, STABLE_TICKS=3) -> io_value[5] stays 0, io_pending stays 0; cnt[5] returns to 0.
- Fall with mask: io_fallEnable=32'h0 then fall on pin 2 -> io_value[2]=0, no pending; repeat with io_fallEnable[2]=1 -> io_pending[2]=1.
- Clear vs set: io_clearPending[0]=1 in the same cycle a new rise on pin 0 sets pending -> io_pending[0] remains 1; a later clear with no event -> 0 and io_interrupt=0.
- Without GPIO_DEBOUNCE_EN: toggle io_dataIn to 32'hA5A5_A5A5 -> io_value=32'hA5A5_A5A5 exactly one cycle later; pending bits set per the enable masks.
